// File: rtl/rr_arbiter_mux_if.sv
// Handshake bundle for rr_arbiter_mux: per-channel requests in, one registered
// selected word out. The slave side is the arbiter, the master side drives it.
interface rr_arbiter_mux_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       ou_ready;
  logic                      in_mode;
  logic [SEL_W-1:0]          in_select;
  logic [WIDTH-1:0]          ou_result;
  logic                      ou_valid;
  logic [SEL_W-1:0]          ou_channel;
  logic                      in_ready;

  modport master (
    output in_data, in_valid, in_mode, in_select, in_ready,
    input  ou_ready, ou_result, ou_valid, ou_channel
  );

  modport slave (
    input  in_data, in_valid, in_mode, in_select, in_ready,
    output ou_ready, ou_result, ou_valid, ou_channel
  );
endinterface

// File: rtl/rr_arbiter_mux.sv
// Channel arbiter + output register: fixed-select or round-robin grant,
// one-word skid-free output stage with downstream backpressure.
module rr_arbiter_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic           in_clk,
  input  logic           in_reset_n,
  rr_arbiter_mux_if.slave bus
);

  localparam logic [SEL_W:0]   CH_N     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    ptr_p1;
  logic [WIDTH-1:0]    result_p1;
  logic [SEL_W-1:0]    channel_p1;
  logic                vld_p1;

  logic                load;
  logic                fix_hit;
  logic                rr_hit;
  logic [SEL_W-1:0]    rr_idx;
  logic                has_grant;
  logic [SEL_W-1:0]    grant;
  logic [CHANNELS-1:0] ready;

  // Stage p0: grant decision, purely combinational from requests and state
  assign load    = !vld_p1 || bus.in_ready;
  assign fix_hit = ({1'b0, bus.in_select} < CH_N) && bus.in_valid[bus.in_select];

  // Walk offsets from far to near so the closest requester after ptr wins
  always_comb begin
    int idx;
    idx    = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr_p1) + k) % CHANNELS;
      if (bus.in_valid[SEL_W'(idx)]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    has_grant = bus.in_mode ? rr_hit : fix_hit;
    grant     = bus.in_mode ? rr_idx : bus.in_select;
    ready     = '0;
    if (in_reset_n && load && has_grant) begin
      ready[grant] = 1'b1;
    end
  end

  assign bus.ou_ready = ready;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      channel_p1 <= '0;
      ptr_p1     <= PTR_INIT;
    end else if (load) begin
      vld_p1 <= has_grant;
      if (has_grant) begin
        result_p1  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
        channel_p1 <= grant;
        if (bus.in_mode) begin
          ptr_p1 <= grant;
        end
      end
    end
  end

  assign bus.ou_result  = result_p1;
  assign bus.ou_valid   = vld_p1;
  assign bus.ou_channel = channel_p1;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Scoreboard bench for rr_arbiter_mux (4 channels x 32 bits): expected words are
// queued when the grant is predicted and popped when the output register loads.
module tb_rr_arbiter_mux;

  logic in_clk = 1'b0;
  logic in_reset_n;

  rr_arbiter_mux_if #(.WIDTH(32), .CHANNELS(4)) bus ();

  rr_arbiter_mux #(.WIDTH(32), .CHANNELS(4)) dut (
    .in_clk     (in_clk),
    .in_reset_n (in_reset_n),
    .bus        (bus.slave)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_t;

  sb_t         sbq[$];
  int          log_ch[$];
  int          n_checks = 0;
  int          n_errors = 0;

  int          m_ptr;
  logic        m_vld;
  logic [31:0] m_res;
  logic [1:0]  m_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input logic mode,
                                     input logic [1:0] sel, input int ptr);
    if (!mode) return v[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  // One clock: predict at the falling edge, compare just after the rising edge
  task automatic step();
    int         g;
    logic       ld;
    logic       mode;
    logic [3:0] er;
    sb_t        it;
    @(negedge in_clk);
    mode = bus.in_mode;
    ld   = !m_vld || bus.in_ready;
    g    = model_grant(bus.in_valid, mode, bus.in_select, m_ptr);
    er   = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("ou_ready", 64'(bus.ou_ready), 64'(er));
    if (ld && g >= 0) sbq.push_back('{ch: 2'(g), data: bus.in_data[g*32 +: 32]});
    @(posedge in_clk);
    #1;
    if (ld && g >= 0) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        it    = sbq.pop_front();
        m_res = it.data;
        m_ch  = it.ch;
        m_vld = 1'b1;
        if (mode) m_ptr = g;
        log_ch.push_back(int'(it.ch));
      end
    end else if (ld) begin
      m_vld = 1'b0;
    end
    chk("ou_valid", 64'(bus.ou_valid), 64'(m_vld));
    chk("ou_result", 64'(bus.ou_result), 64'(m_res));
    chk("ou_channel", 64'(bus.ou_channel), 64'(m_ch));
  endtask

  // Called just after a rising edge; asserts and releases reset between edges
  task automatic do_reset();
    #2;
    in_reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.ou_valid), 64'd0);
    chk("rst_result", 64'(bus.ou_result), 64'd0);
    chk("rst_channel", 64'(bus.ou_channel), 64'd0);
    chk("rst_ready", 64'(bus.ou_ready), 64'd0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    chk("rst_hold_valid", 64'(bus.ou_valid), 64'd0);
    in_reset_n = 1'b1;
    m_vld = 1'b0;
    m_res = '0;
    m_ch  = '0;
    m_ptr = 3;
    sbq.delete();
    log_ch.delete();
  endtask

  task automatic chk_seq(input string tag, input int exp[]);
    chk({tag, "_len"}, 64'(log_ch.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_ch.size(); i++) begin
      chk(tag, 64'(log_ch[i]), 64'(exp[i]));
    end
  endtask

  initial begin
    in_reset_n    = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_mode   = 1'b1;
    bus.in_select = 2'd0;
    bus.in_ready  = 1'b1;
    set_data(32'h0, 32'h0, 32'h0, 32'h0);
    m_vld = 1'b0;
    m_res = '0;
    m_ch  = '0;
    m_ptr = 3;
    #1;
    chk("init_valid", 64'(bus.ou_valid), 64'd0);
    chk("init_result", 64'(bus.ou_result), 64'd0);
    chk("init_channel", 64'(bus.ou_channel), 64'd0);
    chk("init_ready", 64'(bus.ou_ready), 64'd0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    in_reset_n = 1'b1;

    // Round-robin fairness with all channels requesting
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 6; i++) step();
    chk_seq("rr_fair", '{0, 1, 2, 3, 0, 1});

    // Asynchronous reset while a word is held
    chk("pre_rst_valid", 64'(bus.ou_valid), 64'd1);
    do_reset();

    // Skip idle channels and wrap
    bus.in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) step();
    chk_seq("rr_skip", '{0, 3, 0, 3});

    // Fixed select of channel 2
    bus.in_mode   = 1'b0;
    bus.in_select = 2'd2;
    bus.in_valid  = 4'hF;
    set_data(32'h1000, 32'h1001, 32'h1002, 32'h1003);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fix_result", 64'(bus.ou_result), 64'h1002);
      chk("fix_channel", 64'(bus.ou_channel), 64'd2);
    end

    // Backpressure holds the word
    bus.in_select = 2'd1;
    set_data(32'h0, 32'hA5, 32'h0, 32'h0);
    step();
    bus.in_ready = 1'b0;
    set_data(32'h11, 32'hB6, 32'h33, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_result", 64'(bus.ou_result), 64'hA5);
      chk("bp_ready", 64'(bus.ou_ready), 64'd0);
    end
    bus.in_ready = 1'b1;
    step();
    chk("bp_release", 64'(bus.ou_result), 64'hB6);

    // Fixed select of an idle channel drains the output
    bus.in_select = 2'd3;
    bus.in_valid  = 4'b0111;
    step();
    chk("drain_valid", 64'(bus.ou_valid), 64'd0);

    // Randomised mix of modes, selects, requests and backpressure
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.in_mode   = ($urandom_range(0, 3) != 0);
      bus.in_select = 2'($urandom_range(0, 3));
      bus.in_ready  = ($urandom_range(0, 9) < 7);
      set_data($urandom, $urandom, $urandom, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_mux.md
RR_ARBITER_MUX -- requirements
Module: rr_arbiter_mux

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels, range 2..16.
- SEL_W, $clog2(CHANNELS), width of channel index.

REQ-002 Ports SHALL be, one per line:
- in_clk, input, 1, sole clock, rising edge.
- in_reset_n, input, 1, reset; asynchronous, active-low.
- in_data, input, CHANNELS*WIDTH, channel i data at bits [i*WIDTH +: WIDTH].
- in_valid, input, CHANNELS, per-channel request.
- ou_ready, output, CHANNELS, per-channel accept (one-hot or zero).
- in_mode, input, 1, 0 = fixed select, 1 = round-robin.
- in_select, input, SEL_W, channel index used in fixed mode.
- ou_result, output, WIDTH, registered selected data.
- ou_valid, output, 1, ou_result holds an unconsumed word.
- ou_channel, output, SEL_W, source channel of ou_result.
- in_ready, input, 1, downstream accept.

REQ-003 The block SHALL use one clock and one reset only; reset is asynchronous and active-low.

Function
REQ-004 The load enable SHALL be asserted when (!ou_valid || in_ready).

REQ-005 In fixed mode (in_mode=0), the granted channel SHALL be in_select when in_select < CHANNELS and in_valid[in_select]=1; otherwise there is no grant.

REQ-006 In round-robin mode (in_mode=1), the granted channel SHALL be the first i with in_valid[i]=1, searching from (ptr+1) mod CHANNELS upward with wrap-around.

REQ-007 ou_ready SHALL be one-hot on the granted channel when the load enable is asserted, and all-zero otherwise. ou_ready is combinational from in_valid, in_mode, in_select, ptr, ou_valid and in_ready.

REQ-008 A transfer from channel g SHALL occur on a rising edge where in_valid[g] && ou_ready[g]. At that edge, ou_result <= channel g data, ou_channel <= g, and ou_valid <= 1.

REQ-009 On an edge with load enable asserted and no grant, ou_valid SHALL go to 0. ou_result and ou_channel keep their previous values.

REQ-010 While ou_valid=1 and in_ready=0, ou_result, ou_channel and ou_valid SHALL hold stable, and ou_ready SHALL be all-zero.

REQ-011 Latency SHALL be 1 cycle from input transfer to ou_valid. Sustained throughput SHALL be 1 word/cycle while in_ready=1.

REQ-012 The internal pointer ptr SHALL update to g on every transfer in round-robin mode. It SHALL be unchanged in fixed mode.

REQ-013 A change of in_mode or in_select SHALL affect only the next grant decision. It SHALL never alter a word already held in the output register.

REQ-014 Simultaneous drain and load (ou_valid=1, in_ready=1, grant present) SHALL replace the output word in the same edge, with no bubble.

REQ-015 in_data of non-granted channels SHALL have no effect on any output.

Reset
REQ-016 While in_reset_n=0, regardless of clock, the outputs SHALL be: ou_valid=0, ou_result=0, ou_channel=0, ptr=CHANNELS-1, and ou_ready all-zero.

REQ-017 Assertion of reset mid-transfer SHALL discard the held word. The first grant after release in round-robin mode SHALL search from channel 0.

REQ-018 Reset release SHALL take effect at the first rising edge of in_clk after in_reset_n goes high.

Verification
REQ-019 Reset check: pulse in_reset_n low between clock edges while ou_valid=1 -> ou_valid=0, ou_result=0 and ou_channel=0 immediately, without waiting for a clock edge.

REQ-020 Fixed mode, CHANNELS=4, WIDTH=32:
- Stimulus: in_select=2, all in_valid=1, data[i]=32'h1000+i, in_ready=1.
- Response: ou_ready=4'b0100 every cycle, ou_result=32'h1002, ou_channel=2, one cycle after each edge.

REQ-021 Round-robin fairness:
- Stimulus: all four channels valid continuously, in_ready=1, starting from reset.
- Response: ou_channel sequence 0,1,2,3,0,1.

REQ-022 Round-robin skip and wrap:
- Stimulus: in_valid=4'b1001, starting from reset.
- Response: grants 0,3,0,3. Channels 1 and 2 are never granted.

REQ-023 Backpressure:
- Stimulus: ou_valid=1 with ou_result=32'hA5, then in_ready=0 for 3 cycles.
- Response: ou_result stays 32'hA5 and ou_ready=0 for all 3 cycles. Data changes only on the edge where in_ready=1.

REQ-024 Out-of-range select and drain:
- Stimulus: in_mode=0, in_select=5 with CHANNELS=5... use CHANNELS=4 and in_select=3 with in_valid[3]=0, in_ready=1.
- Response: ou_ready=0, and ou_valid goes to 0 after one edge.
